// File: rtl/fir_pkg.sv
// Shared sample-format constants and typedefs for the FIR datapath and its back end.
package fir_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int ACC_W      = 32;
    localparam int FRAC_SHIFT = 15;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    localparam sample_t Q15_MAX = 16'sh7FFF;
    localparam sample_t Q15_MIN = 16'sh8000;

endpackage

// File: rtl/fir_out_fifo.sv
// Small synchronous FIFO with occupancy count; read data reads as zero while empty.
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                level <= level + (AW+1)'(1);
            else if (do_pop && !do_push)
                level <= level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output back end: decimate, round/saturate Q2.30 to Q1.15, buffer for a valid/ready sink.
// Define FIR_REQUANT_CONV_ROUND_EN for round-half-to-even instead of round-half-up.
module fir_out_requant #(
    parameter int IN_WIDTH   = fir_pkg::ACC_W,
    parameter int OUT_WIDTH  = fir_pkg::SAMPLE_W,
    parameter int FRAC_SHIFT = fir_pkg::FRAC_SHIFT,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           rst,
    input  logic signed [IN_WIDTH-1:0]     sample_in,
    input  logic                           in_valid,
    output logic signed [OUT_WIDTH-1:0]    out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           sat_flag,
    output logic                           ovf_err,
    input  logic                           err_clr
);

    localparam int PW = $clog2(DECIM + 1);
    localparam int RW = IN_WIDTH + 1;
    localparam logic signed [RW-1:0] HALF    = RW'(1) <<< (FRAC_SHIFT - 1);
    localparam logic signed [RW-1:0] OUT_MAX = RW'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [RW-1:0] OUT_MIN = RW'(-(2**(OUT_WIDTH-1)));

    function automatic logic signed [RW-1:0] round_shift(input logic signed [IN_WIDTH-1:0] x);
        logic signed [RW-1:0] ext;
        logic signed [RW-1:0] bias;
        ext  = {x[IN_WIDTH-1], x};
        bias = HALF;
`ifdef FIR_REQUANT_CONV_ROUND_EN
        // Exact tie with an even truncated result: keep it rather than rounding up.
        if (x[FRAC_SHIFT-1:0] == HALF[FRAC_SHIFT-1:0] && !x[FRAC_SHIFT])
            bias = '0;
`endif
        return (ext + bias) >>> FRAC_SHIFT;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [RW-1:0] v);
        if (v > OUT_MAX) return {1'b0, {(OUT_WIDTH-1){1'b1}}};
        if (v < OUT_MIN) return {1'b1, {(OUT_WIDTH-1){1'b0}}};
        return v[OUT_WIDTH-1:0];
    endfunction

    logic [PW-1:0]               phase;
    logic                        keep;
    logic signed [RW-1:0]        rounded;
    logic                        clip;
    logic signed [OUT_WIDTH-1:0] requant;
    logic                        full;
    logic                        empty;
    logic                        pop_ok;

    // Decimation: phase only moves on valid FIR samples, phase 0 is kept.
    assign keep = in_valid && (phase == '0);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst)
            phase <= '0;
        else if (in_valid)
            phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
    end

    // Requantization, combinational on the incoming sample.
    assign rounded = round_shift(sample_in);
    assign clip    = (rounded > OUT_MAX) || (rounded < OUT_MIN);
    assign requant = saturate(rounded);
    assign pop_ok  = out_valid && out_ready;

    // Sticky error flags; a new event in the same cycle overrides a clear.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            if (err_clr) begin
                sat_flag <= 1'b0;
                ovf_err  <= 1'b0;
            end
            if (keep && clip)
                sat_flag <= 1'b1;
            if (keep && full && !pop_ok)
                ovf_err <= 1'b1;
        end
    end

    // Output buffer stage.
    fir_out_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (rst),
        .push  (keep),
        .pop   (out_ready),
        .wdata (requant),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign out_valid = !empty;

endmodule

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
- Back-end consumer for the FIR filter output stream.
- Takes full-precision 32-bit Q2.30 filter results, qualified by the FIR enable strobe.
- Decimates by a fixed factor, then rounds and saturates to 16-bit Q1.15.
- Buffers results in a small FIFO and hands them downstream over a valid/ready interface. The FIR has no backpressure, so overflow is flagged, never stalled.

Parameters:
- IN_WIDTH, 32, width of the incoming FIR result (signed, two's complement).
- OUT_WIDTH, 16, width of the requantized output sample (signed).
- FRAC_SHIFT, 15, right-shift applied before rounding (Q2.30 to Q1.15).
- DECIM, 4, decimation factor; legal range 1..16.
- FIFO_DEPTH, 4, output buffer entries; must be a power of 2, at least 2.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sample_in  input  IN_WIDTH  FIR result, signed.
- in_valid  input  1  sample_in is valid this cycle (driven from the FIR enable).
- out_data  output  OUT_WIDTH  requantized sample at FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts out_data this cycle.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count.
- sat_flag  output  1  sticky: at least one output saturated.
- ovf_err  output  1  sticky: at least one kept sample dropped because the FIFO was full.
- err_clr  input  1  synchronous clear of sat_flag and ovf_err.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, out_data=0, fifo_level=0, sat_flag=0, ovf_err=0.
  - Phase counter=0; FIFO pointers=0.
  - Reset asserted mid-stream flushes all buffered samples.
- Decimation:
  - The phase counter advances only on in_valid, wrapping from DECIM-1 to 0.
  - A sample is "kept" when in_valid=1 and phase==0. The first valid sample after reset is kept.
  - With DECIM=1 every valid sample is kept.
- Requantization (combinational, on kept sample):
  - Sign-extend to IN_WIDTH+1 bits.
  - Add 2^(FRAC_SHIFT-1) (round half up).
  - Arithmetic shift right by FRAC_SHIFT.
  - Saturate: above 2^(OUT_WIDTH-1)-1 gives 0x7FFF; below -2^(OUT_WIDTH-1) gives 0x8000.
  - Any saturation of a kept sample sets sat_flag (even if that sample is later dropped).
- FIFO:
  - Push on a kept sample. Pop when out_valid && out_ready.
  - A push on cycle N makes the sample visible on out_data/out_valid at cycle N+1 (latency 1 from an empty FIFO).
  - Ordering is first-in, first-out. Pointers wrap modulo FIFO_DEPTH.
- Boundary conditions:
  - Full, push without pop: sample dropped, ovf_err set, contents unchanged.
  - Full, simultaneous push and pop: both occur, level stays FIFO_DEPTH, no error.
  - Empty, pop: impossible (out_valid=0), ignored.
  - Empty: out_data forced to 0.
  - err_clr together with a new error event: the set wins.
- Downstream handshake: out_data is held stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: FIR_REQUANT_CONV_ROUND_EN.
- Defined: convergent rounding (round half to even). An exact .5 fraction rounds toward the even result. Saturation rules are unchanged.
- Undefined: round half up, as described above.

Decomposition:
- Shared package fir_pkg:
  - Sample width constants (16 in, 32 result).
  - FRAC_SHIFT.
  - Q-format saturation limits (Q15_MAX=0x7FFF, Q15_MIN=0x8000).
  - Sample typedefs (sample_t, acc_t).
- Sub-module fir_out_fifo:
  - Parameterized sync FIFO with push/pop/full/empty/level.
  - Zero output when empty.
- Requantizer and phase counter stay in the top block.

Test Plan:
- Rounding (DECIM=1, ready=1):
  - sample_in 0x0000_4000 -> out_data 0x0001 (conv-round build: 0x0000).
  - 0x0000_C000 -> 0x0002 in both builds.
  - 0xFFFF_C000 -> 0x0000 in both builds.
- Saturation:
  - 0x4000_0000 -> 0x7FFF and sat_flag=1.
  - 0xC000_0000 -> 0x8000 with sat_flag unchanged after err_clr.
  - 0xBFFF_0000 -> 0x8000 and sat_flag=1.
- Decimation (DECIM=4): 8 valid inputs of value k<<15, k=1..8, with idle gaps between them -> exactly two outputs, 0x0001 then 0x0005.
- Overflow (DECIM=1, FIFO_DEPTH=4, out_ready=0): push 5 samples 1..5 -> fifo_level=4 and ovf_err=1; raising out_ready drains 1,2,3,4 in order; on a full FIFO, push with pop -> no error.
- Backpressure: out_ready toggled 1/0 randomly -> out_data held stable while stalled, no loss or duplication over 100 samples.
- Reset mid-stream: level=3, assert rst -> out_valid=0, level=0, flags=0 immediately; next valid input is kept (phase 0).
